// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC types and constants for the vectoring/rotation blocks
package cordic_pkg;
  localparam int CORDIC_WIDTH_DEF = 22;
  localparam int MICRO_ROT_STAGE_DEF = 15;
  localparam logic CW = 1'b0;
  localparam logic CCW = 1'b1;
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cordic_rot_micro_step.sv
// cordic_rot_micro_step: one combinational shift-add CORDIC micro-rotation
module cordic_rot_micro_step
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH_DEF,
  parameter int SHIFT_W = 4
) (
  input  logic signed [WIDTH-1:0]   x_i,
  input  logic signed [WIDTH-1:0]   y_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      dir_i,
  output logic signed [WIDTH-1:0]   x_o,
  output logic signed [WIDTH-1:0]   y_o
);
  logic signed [WIDTH-1:0] xs, ys;
  assign xs = x_i >>> shift_i;
  assign ys = y_i >>> shift_i;
  always_comb begin
    x_o = dir_i == CCW ? x_i - ys : x_i + ys;
    y_o = dir_i == CCW ? y_i + xs : y_i - xs;
  end
endmodule

// File: rtl/cordic_rot_iterative.sv
// cordic_rot_iterative: iterative rotation-mode CORDIC replaying a vectoring direction word
// One micro-rotation per clock; result is unscaled (gain K) like the vectoring x output.
module cordic_rot_iterative
  import cordic_pkg::*;
#(
  parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
  parameter int MICRO_ROT_STAGE = MICRO_ROT_STAGE_DEF
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [CORDIC_WIDTH-1:0] x_in,
  input  logic signed [CORDIC_WIDTH-1:0] y_in,
  input  logic [MICRO_ROT_STAGE-1:0]     micro_rot_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [CORDIC_WIDTH-1:0] x_out,
  output logic signed [CORDIC_WIDTH-1:0] y_out,
  output logic                           busy
);
  localparam int CNT_W = cnt_w(MICRO_ROT_STAGE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MICRO_ROT_STAGE - 1);
  state_t st_q, st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [MICRO_ROT_STAGE-1:0] rot_q;
  logic signed [CORDIC_WIDTH-1:0] x_q, y_q, x_d, y_d, xo_q, yo_q;
  logic accept, last;
  assign accept = in_valid && st_q == IDLE;
  assign last = cnt_q == LAST;
  cordic_rot_micro_step #(.WIDTH(CORDIC_WIDTH), .SHIFT_W(CNT_W)) u_step (
    .x_i(x_q), .y_i(y_q), .shift_i(cnt_q), .dir_i(rot_q[0]), .x_o(x_d), .y_o(y_d)
  );
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) st_q <= IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q == IDLE   ? (in_valid ? ROTATE : IDLE) :
           st_q == ROTATE ? (last ? DONE : ROTATE) :
                            (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = st_q == IDLE;
    out_valid = st_q == DONE;
    busy = st_q != IDLE;
  end
  // Direction word shifts right so the current stage's bit is always bit 0.
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      x_q <= '0;
      y_q <= '0;
      rot_q <= '0;
      cnt_q <= '0;
      xo_q <= '0;
      yo_q <= '0;
    end else if (accept) begin
      x_q <= x_in;
      y_q <= y_in;
      rot_q <= micro_rot_in;
      cnt_q <= '0;
    end else if (st_q == ROTATE) begin
      x_q <= x_d;
      y_q <= y_d;
      rot_q <= rot_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        xo_q <= x_d;
        yo_q <= y_d;
      end
    end
  assign x_out = xo_q;
  assign y_out = yo_q;
endmodule

// File: tb/tb_cordic_rot_iterative.sv
// tb_cordic_rot_iterative: directed checks of the iterative rotation CORDIC (N=1, N=2, N=15)
module tb_cordic_rot_iterative;
  logic clk = 0, nreset = 0, out_ready = 1;
  logic iv0 = 0, iv1 = 0, iv2 = 0;
  logic signed [21:0] x_in = '0, y_in = '0;
  logic [14:0] word = '0;
  logic ir0, ov0, b0, ir1, ov1, b1, ir2, ov2, b2;
  logic signed [21:0] xo0, yo0, xo1, yo1, xo2, yo2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  cordic_rot_iterative u_dut0 (
    .clk(clk), .nreset(nreset), .in_valid(iv0), .in_ready(ir0), .x_in(x_in), .y_in(y_in),
    .micro_rot_in(word), .out_valid(ov0), .out_ready(out_ready), .x_out(xo0), .y_out(yo0), .busy(b0)
  );
  cordic_rot_iterative #(.MICRO_ROT_STAGE(1)) u_dut1 (
    .clk(clk), .nreset(nreset), .in_valid(iv1), .in_ready(ir1), .x_in(x_in), .y_in(y_in),
    .micro_rot_in(word[0:0]), .out_valid(ov1), .out_ready(out_ready), .x_out(xo1), .y_out(yo1), .busy(b1)
  );
  cordic_rot_iterative #(.MICRO_ROT_STAGE(2)) u_dut2 (
    .clk(clk), .nreset(nreset), .in_valid(iv2), .in_ready(ir2), .x_in(x_in), .y_in(y_in),
    .micro_rot_in(word[1:0]), .out_valid(ov2), .out_ready(out_ready), .x_out(xo2), .y_out(yo2), .busy(b2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference vectoring chain: drives y toward 0 and records the direction per stage.
  task automatic vec_model(input int x0, input int y0, output logic [14:0] w, output int xf, output int yf);
    logic signed [21:0] x, y, t;
    x = 22'(x0);
    y = 22'(y0);
    for (int i = 0; i < 15; i++) begin
      w[i] = y < 0;
      if (w[i]) begin
        t = x - (y >>> i);
        y = y + (x >>> i);
      end else begin
        t = x + (y >>> i);
        y = y - (x >>> i);
      end
      x = t;
    end
    xf = int'(x);
    yf = int'(y);
  endtask

  task automatic run0(input int x, input int y, input logic [14:0] w, output int lat);
    int guard = 0;
    while (!ir0 && guard < 100) begin
      step;
      guard++;
    end
    x_in = 22'(x);
    y_in = 22'(y);
    word = w;
    iv0 = 1;
    step;
    iv0 = 0;
    lat = 0;
    while (!ov0 && lat < 100) begin
      step;
      lat++;
    end
  endtask

  initial begin
    logic [14:0] w;
    int xe, ye, lat, yabs;
    logic signed [21:0] xs, ys;
    step;
    step;
    chk("rst_ov", ov0, 0);
    chk("rst_x", xo0, 0);
    chk("rst_y", yo0, 0);
    chk("rst_busy", b0, 0);
    nreset = 1;
    step;
    chk("rst_in_ready", ir0, 1);

    x_in = 100; y_in = 50; word = '0; iv1 = 1;
    step;
    iv1 = 0;
    chk("n1_ov_c0", ov1, 0);
    step;
    chk("n1_ov_c1", ov1, 1);
    chk("n1_x", xo1, 150);
    chk("n1_y", yo1, -50);
    chk("n1_in_ready", ir1, 0);
    step;

    x_in = 0; y_in = -3; word = 15'b10; iv2 = 1;
    step;
    iv2 = 0;
    step;
    chk("n2_ov_c1", ov2, 0);
    step;
    chk("n2_ov_c2", ov2, 1);
    chk("n2_x", xo2, -1);
    chk("n2_y", yo2, -5);
    step;

    vec_model(12000, -7000, w, xe, ye);
    run0(12000, -7000, w, lat);
    chk("lb_lat", lat, 15);
    chk("lb_x", xo0, xe);
    yabs = yo0 < 0 ? -int'(yo0) : int'(yo0);
    chk("lb_yres", yabs <= 15, 1);
    chk("lb_mag", xo0 > 22800 && xo0 < 22920, 1);
    chk("lb_in_ready", ir0, 0);

    out_ready = 0;
    step;
    run0(12000, -7000, w, lat);
    xs = xo0;
    ys = yo0;
    for (int k = 0; k < 10; k++) begin
      iv0 = k[0];
      x_in = 22'(k * 77);
      step;
      chk("bp_ov", ov0, 1);
      chk("bp_in_ready", ir0, 0);
      chk("bp_x", xo0, xs);
      chk("bp_y", yo0, ys);
    end
    iv0 = 0;
    out_ready = 1;
    step;
    chk("bp_rel_in_ready", ir0, 1);
    chk("bp_rel_ov", ov0, 0);
    vec_model(5000, 3000, w, xe, ye);
    run0(5000, 3000, w, lat);
    chk("bp_next_lat", lat, 15);
    chk("bp_next_x", xo0, xe);
    chk("bp_next_y", yo0, ye);
    step;

    vec_model(12000, -7000, w, xe, ye);
    x_in = 12000; y_in = -7000; word = w; iv0 = 1;
    step;
    iv0 = 0;
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      x_in = -x_in;
      word = ~word;
      iv0 = 1;
      step;
      lat++;
    end
    iv0 = 0;
    while (!ov0 && lat < 100) begin
      step;
      lat++;
    end
    chk("chg_lat", lat, 15);
    chk("chg_x", xo0, xe);
    chk("chg_y", yo0, ye);
    step;

    x_in = 5000; y_in = 3000; word = 15'h1234; iv0 = 1;
    step;
    iv0 = 0;
    for (int k = 0; k < 7; k++) step;
    chk("mid_busy", b0, 1);
    nreset = 0;
    #1;
    chk("arst_x", xo0, 0);
    chk("arst_y", yo0, 0);
    chk("arst_ov", ov0, 0);
    chk("arst_busy", b0, 0);
    step;
    nreset = 1;
    step;
    chk("post_in_ready", ir0, 1);
    chk("post_ov", ov0, 0);
    vec_model(-9000, 4000, w, xe, ye);
    run0(-9000, 4000, w, lat);
    chk("post_lat", lat, 15);
    chk("post_x", xo0, xe);
    chk("post_y", yo0, ye);
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_rot_iterative.md
Name: cordic_rot_iterative

Overview:
- Rotation-mode counterpart of the pipelined vectoring chain.
- Consumes the per-stage micro-rotation direction word produced by vectoring and applies that same rotation sequence to a new (x, y) vector, e.g. the remaining matrix columns in the ICA/Givens flow.
- Iterative: one micro-rotation per clock over a single shared shift-add datapath, with valid/ready handshakes on both sides.
- Output is unscaled (CORDIC gain K≈1.6468), so it matches the vectoring x output directly.

Parameters:
- CORDIC_WIDTH, 22, two's-complement width of x/y.
- MICRO_ROT_STAGE, 15, number of micro-rotations N (stages 0..N-1, shift = stage index).

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input vector and direction word valid.
- in_ready  output  1  block can accept a new job.
- x_in  input  CORDIC_WIDTH  signed x.
- y_in  input  CORDIC_WIDTH  signed y.
- micro_rot_in  input  MICRO_ROT_STAGE  direction word; bit i applies to stage i (0 = clockwise, 1 = counter-clockwise).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- x_out  output  CORDIC_WIDTH  rotated x.
- y_out  output  CORDIC_WIDTH  rotated y.
- busy  output  1  job in progress (state != IDLE).

Behaviour:
- Reset (async, nreset low): state=IDLE, counter=0; x/y/direction registers=0; out_valid=0, x_out=0, y_out=0, busy=0, in_ready=1 after reset release. Reset mid-job aborts the job silently; no output is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x_in, y_in, micro_rot_in; counter=0; go to ROTATE.
  - ROTATE: each cycle apply stage i=counter, then counter++. At counter==N-1, apply the last stage and go to DONE.
  - DONE: out_valid=1, x_out/y_out hold the final values. On out_ready, go to IDLE. No new job is accepted in the same cycle as the DONE→IDLE transition.
- Stage i, with d = direction bit i:
  - d=0: x' = x + (y>>>i), y' = y - (x>>>i).
  - d=1: x' = x - (y>>>i), y' = y + (x>>>i).
- Shifts are arithmetic (sign-extended, floor toward -inf). Add/sub at CORDIC_WIDTH with two's-complement wrap and no saturation. Upstream guarantees headroom for gain K.
- Latency: the acceptance edge is cycle 0; out_valid rises at cycle N. Throughput is one job per N+2 cycles minimum.
- in_ready and out_valid are never high together.
- out_valid held with out_ready low: outputs stay stable indefinitely.
- in_valid while busy: ignored, because in_ready=0. Inputs are not sampled.
- micro_rot_in is sampled only at acceptance; later changes have no effect.
- x_out/y_out are registered and change only on the final ROTATE update.

Decomposition:
- Shared package cordic_pkg holds:
  - state enum {IDLE, ROTATE, DONE};
  - the default CORDIC_WIDTH/MICRO_ROT_STAGE constants;
  - the direction-bit encoding constants CW=0, CCW=1, shared with the vectoring stages.
- Sub-module cordic_rot_micro_step: combinational single-stage shift-add; inputs x, y, shift amount, direction bit; outputs x', y'.
- Top level: FSM, counter, registers.

Test Plan:
- N=1 override; x=100, y=50, word=1'b0 → x_out=150, y_out=-50; out_valid exactly 1 cycle after acceptance.
- N=2; x=0, y=-3, word=2'b10 → stage0 gives (-3,-3); final x_out=-1, y_out=-5. Checks the arithmetic-shift floor.
- Default params, loop-back: run (x,y)=(12000,-7000) through the vectoring chain and feed its direction bits here with the same (x,y) → x_out equals the vectoring x_out exactly, |y_out| ≤ N LSB; out_valid at cycle 15.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0; in_valid pulses ignored. Release → IDLE, then the next job is accepted one cycle later.
- Input change: toggle micro_rot_in/x_in during ROTATE → result identical to a run with the undisturbed values.
- Reset: assert nreset at counter=7 → all outputs 0 immediately. After release, in_ready=1, no out_valid; a new job completes correctly.
